lc3_alu_sequencer: RTL and testbench
====================================

# lc3_alu_sequencer

Control-side counterpart of the LC-3 ALU. It accepts operate instructions (ADD, AND, NOT) over a valid/ready handshake and holds an 8×16 general-purpose register file. It reads the source operands, drives the ALU's operand and control inputs, captures the ALU result, writes it back to the destination register, and updates the NZP condition codes. It sits between the instruction source and the combinational ALU. The ALU is instantiated outside this block.

## Interface
No parameters; widths are fixed by the LC-3 ISA.
- Clk  in  1  system clock; all state updates on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Instr_Valid  in  1  instruction offered on Instr
- Instr  in  16  LC-3 instruction word
- Instr_Ready  out  1  block can accept an instruction (high only in IDLE)
- Wr_En  in  1  external register-load strobe (honoured only in IDLE)
- Wr_Addr  in  3  external load register index
- Wr_Data  in  16  external load data
- ALU_Result  in  16  result returned by the external ALU
- IR_Out  out  16  latched instruction, to ALU IR input
- SR1_Data  out  16  SR1 operand, to ALU
- SR2_Data  out  16  SR2 operand, to ALU
- ALUK  out  2  ALU function: 00 add, 01 and, 10 not, 11 pass
- SR2MUX  out  1  1 = ALU uses the sign-extended IR[4:0] immediate
- Done  out  1  one-cycle pulse in the writeback cycle
- Illegal  out  1  one-cycle pulse when the opcode is not ADD, AND or NOT
- NZP  out  3  condition codes {N,Z,P}
- Dbg_Sel  in  3  debug read register index
- Dbg_Data  out  16  combinational read of register Dbg_Sel

## Operation
- FSM states: IDLE → DECODE → EXEC → WB → IDLE. DECODE → IDLE on an illegal opcode.
- **IDLE**
  - Instr_Ready=1.
  - On Instr_Valid & Instr_Ready at a rising edge: latch Instr into IR and go to DECODE.
  - Wr_En writes Wr_Data to R[Wr_Addr] at the edge.
  - If Wr_En and the accept occur at the same edge, both happen. DECODE reads the newly written value.
- **DECODE**
  - Opcode IR[15:12] 0001=ADD, 0101=AND, 1001=NOT.
  - Any other opcode: Illegal=1 for this cycle, then IDLE. No register or NZP change.
  - Legal opcode:
    - Register SR1_Data ← R[IR[8:6]] and SR2_Data ← R[IR[2:0]].
    - ALUK ← 00/01/10 per opcode.
    - SR2MUX ← IR[5] for ADD/AND, 0 for NOT.
    - Go to EXEC.
- **EXEC**
  - Operand and control outputs are stable.
  - Capture ALU_Result into the internal result register at the end of the cycle.
  - Go to WB.
- **WB**
  - Done=1.
  - At the closing edge: R[IR[11:9]] ← result.
  - At the same edge: NZP ← 100 if result[15], 010 if result==0, else 001.
  - Go to IDLE.
- Don't-care fields:
  - For NOT, IR[5:0] is ignored.
  - For register-mode ADD/AND, IR[4:3] is ignored.
- Wr_En, and Instr_Valid outside IDLE, are ignored. No buffering.
- Outside DECODE/EXEC/WB, ALUK=11 and SR2MUX=0. SR1/SR2/IR_Out hold their last values.
- Dbg_Data = R[Dbg_Sel], combinational. A write becomes visible the cycle after its edge.

## Timing
- Reset (async assert, sync-safe deassert):
  - State=IDLE, all R[0..7]=0x0000, IR_Out=SR1_Data=SR2_Data=0x0000.
  - ALUK=11, SR2MUX=0, Done=0, Illegal=0, NZP=010, Instr_Ready=1.
- Latency, with the accept edge as edge 0:
  - DECODE occupies cycle 1, EXEC cycle 2, WB cycle 3 (Done high).
  - Register/NZP update at edge 4.
  - Instr_Ready is high again in cycle 4.
  - Throughput is 1 instruction per 4 cycles.
- Illegal instruction: Illegal high in cycle 1, Instr_Ready high in cycle 2.
- External ALU must be combinational. ALU_Result is sampled only at the end of EXEC.
- Reset mid-operation (any state): the instruction is dropped, no Done/Illegal, and all reset values apply immediately.
- A destination register equal to a source register is legal. The operands were latched in DECODE, so the write has no hazard.

## Test plan
- **Reset:** assert Reset_n=0 mid-cycle → Instr_Ready=1, NZP=010, Dbg_Data=0x0000 for all Dbg_Sel, ALUK=11.
- **Register ADD:**
  - Setup: load R1=0x0005 and R2=0xFFFD via Wr_En. Issue 0x1642 (ADD R3,R1,R2).
  - Required: ALUK=00 and SR2MUX=0 in EXEC, Done in cycle 3, R3=0x0002, NZP=001.
- **Immediate ADD:** issue 0x1870 (ADD R4,R1,#-16) → SR2MUX=1 in EXEC, R4=0xFFF5, NZP=100.
- **AND and NOT:**
  - Issue 0x5AA0 (AND R5,R2,#0) → R5=0x0000, NZP=010.
  - Then issue 0x9C7F (NOT R6,R1) → ALUK=10, R6=0xFFFA, NZP=100.
- **Illegal opcode:** issue 0x0000 → Illegal pulse in cycle 1, no Done, registers and NZP unchanged, Instr_Ready high in cycle 2.
- **Handshake and reset edge cases:**
  - Hold Instr_Valid high with Wr_En=1 throughout a busy instruction → no second accept and no write until IDLE.
  - Assert Reset_n=0 during EXEC of 0x1642 → no Done, R3=0x0000, NZP=010.

Source files
------------

// File: rtl/lc3_alu_sequencer.sv
// ---------------------------------------------------------------------------
// lc3_alu_sequencer
//
// Control-side sequencer for an external, purely combinational LC-3 ALU.
// It accepts ADD/AND/NOT operate instructions over a valid/ready handshake.
// It also holds the 8x16 general-purpose register file, fetches operands,
// captures the ALU result, writes it back and updates the NZP codes.
// A legal instruction flows IDLE -> DECODE -> EXEC -> WB -> IDLE.
// An illegal opcode flows IDLE -> DECODE -> IDLE.
//
// Ports
//   Clk, Reset_n        clock, asynchronous active-low reset
//   Instr_Valid/Instr   instruction offer; Instr_Ready is high only in IDLE
//   Wr_En/Wr_Addr/Wr_Data  external register load, honoured only in IDLE
//   ALU_Result          result from the external ALU, sampled at end of EXEC
//   IR_Out, SR1_Data, SR2_Data, ALUK, SR2MUX   operands/control to the ALU
//   Done                one-cycle pulse in the writeback cycle
//   Illegal             one-cycle pulse in DECODE for an unsupported opcode
//   NZP                 condition codes {N,Z,P}
//   Dbg_Sel/Dbg_Data    combinational register-file read port
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module lc3_alu_sequencer (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Instr_Valid,
    input  logic [15:0] Instr,
    output logic        Instr_Ready,
    input  logic        Wr_En,
    input  logic [2:0]  Wr_Addr,
    input  logic [15:0] Wr_Data,
    input  logic [15:0] ALU_Result,
    output logic [15:0] IR_Out,
    output logic [15:0] SR1_Data,
    output logic [15:0] SR2_Data,
    output logic [1:0]  ALUK,
    output logic        SR2MUX,
    output logic        Done,
    output logic        Illegal,
    output logic [2:0]  NZP,
    input  logic [2:0]  Dbg_Sel,
    output logic [15:0] Dbg_Data
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_t;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;

    localparam logic [1:0] ALUK_ADD  = 2'b00;
    localparam logic [1:0] ALUK_AND  = 2'b01;
    localparam logic [1:0] ALUK_NOT  = 2'b10;
    localparam logic [1:0] ALUK_PASS = 2'b11;

    state_t      state;
    state_t      state_next;

    logic [15:0] ir;
    logic [15:0] sr1;
    logic [15:0] sr2;
    logic [15:0] result;
    logic [2:0]  nzp;
    logic [15:0] regs [8];

    logic        is_add;
    logic        is_and;
    logic        is_not;
    logic        legal;

    // The IR is stable from DECODE through WB, so the opcode decode can be
    // used directly in every busy state without a separate control register.
    assign is_add = (ir[15:12] == OP_ADD);
    assign is_and = (ir[15:12] == OP_AND);
    assign is_not = (ir[15:12] == OP_NOT);
    assign legal  = is_add | is_and | is_not;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control outputs
    // ------------------------------------------------------------------
    // NOTE: every output of this block is given a default first; a missing
    // assignment on any path would otherwise infer a latch.
    always_comb begin
        state_next  = state;
        Instr_Ready = 1'b0;
        ALUK        = ALUK_PASS;
        SR2MUX      = 1'b0;
        Done        = 1'b0;
        Illegal     = 1'b0;

        case (state)
            S_IDLE: begin
                Instr_Ready = 1'b1;
                if (Instr_Valid) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (legal) begin
                    state_next = S_EXEC;
                end else begin
                    Illegal    = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_EXEC: begin
                state_next = S_WB;
            end
            S_WB: begin
                Done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // ALU control is driven only while a legal instruction is in flight.
        if (state != S_IDLE && legal) begin
            if (is_add) begin
                ALUK = ALUK_ADD;
            end else if (is_and) begin
                ALUK = ALUK_AND;
            end else begin
                ALUK = ALUK_NOT;
            end
            // NOT has no second operand, so its IR[5] is a don't-care.
            SR2MUX = (is_add | is_and) & ir[5];
        end
    end

    // ------------------------------------------------------------------
    // Datapath: IR, operand latches, result, register file, NZP
    // ------------------------------------------------------------------
    // NOTE: the register file is reset explicitly because the architecture
    // defines all GPRs as zero after reset; this keeps it in flops rather
    // than an inferred RAM, which is fine at 8x16.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ir     <= '0;
            sr1    <= '0;
            sr2    <= '0;
            result <= '0;
            nzp    <= 3'b010;
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (Instr_Valid) begin
                        ir <= Instr;
                    end
                    // A load coinciding with an accept lands before DECODE
                    // reads the register file, so DECODE sees the new value.
                    if (Wr_En) begin
                        regs[Wr_Addr] <= Wr_Data;
                    end
                end
                S_DECODE: begin
                    if (legal) begin
                        sr1 <= regs[ir[8:6]];
                        sr2 <= regs[ir[2:0]];
                    end
                end
                S_EXEC: begin
                    result <= ALU_Result;
                end
                S_WB: begin
                    // Operands were latched in DECODE, so DR == SR is safe.
                    regs[ir[11:9]] <= result;
                    if (result[15]) begin
                        nzp <= 3'b100;
                    end else if (result == 16'h0000) begin
                        nzp <= 3'b010;
                    end else begin
                        nzp <= 3'b001;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign IR_Out   = ir;
    assign SR1_Data = sr1;
    assign SR2_Data = sr2;
    assign NZP      = nzp;
    assign Dbg_Data = regs[Dbg_Sel];

endmodule

// File: tb/tb_lc3_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lc3_alu_sequencer
//
// Directed bench for lc3_alu_sequencer. The bench supplies a behavioural
// combinational ALU. Stimulus pushes the expected response of each issued
// instruction into a scoreboard queue. A monitor pops and compares whenever
// the DUT raises Done or Illegal.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_lc3_alu_sequencer;

    logic        Clk;
    logic        Reset_n;
    logic        Instr_Valid;
    logic [15:0] Instr;
    logic        Instr_Ready;
    logic        Wr_En;
    logic [2:0]  Wr_Addr;
    logic [15:0] Wr_Data;
    logic [15:0] ALU_Result;
    logic [15:0] IR_Out;
    logic [15:0] SR1_Data;
    logic [15:0] SR2_Data;
    logic [1:0]  ALUK;
    logic        SR2MUX;
    logic        Done;
    logic        Illegal;
    logic [2:0]  NZP;
    logic [2:0]  Dbg_Sel;
    logic [15:0] Dbg_Data;

    lc3_alu_sequencer dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .Instr_Valid (Instr_Valid),
        .Instr       (Instr),
        .Instr_Ready (Instr_Ready),
        .Wr_En       (Wr_En),
        .Wr_Addr     (Wr_Addr),
        .Wr_Data     (Wr_Data),
        .ALU_Result  (ALU_Result),
        .IR_Out      (IR_Out),
        .SR1_Data    (SR1_Data),
        .SR2_Data    (SR2_Data),
        .ALUK        (ALUK),
        .SR2MUX      (SR2MUX),
        .Done        (Done),
        .Illegal     (Illegal),
        .NZP         (NZP),
        .Dbg_Sel     (Dbg_Sel),
        .Dbg_Data    (Dbg_Data)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // Behavioural LC-3 ALU.
    logic [15:0] alu_b;
    always_comb begin
        alu_b      = SR2MUX ? {{11{IR_Out[4]}}, IR_Out[4:0]} : SR2_Data;
        ALU_Result = SR1_Data;
        case (ALUK)
            2'b00:   ALU_Result = SR1_Data + alu_b;
            2'b01:   ALU_Result = SR1_Data & alu_b;
            2'b10:   ALU_Result = ~SR1_Data;
            default: ALU_Result = SR1_Data;
        endcase
    end

    int tests  = 0;
    int errors = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [15:0] instr;
        logic        is_illegal;
        logic [2:0]  nzp;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Monitor: latency is counted in cycles after the accept edge.
    always @(negedge Clk) begin
        if (Reset_n && (Done || Illegal)) begin
            if (sb.size() == 0) begin
                check("unexpected_response", {14'b0, Done, Illegal}, 16'h0000);
            end else begin
                mon_e = sb.pop_front();
                check("resp_kind_illegal", {15'b0, Illegal}, {15'b0, mon_e.is_illegal});
                check("resp_kind_done", {15'b0, Done}, {15'b0, !mon_e.is_illegal});
                check("resp_ir", IR_Out, mon_e.instr);
                check("resp_latency", 16'(cyc - mon_e.acc), mon_e.is_illegal ? 16'd1 : 16'd3);
                if (!mon_e.is_illegal) begin
                    @(posedge Clk);
                    #1;
                    check("nzp_after_wb", {13'b0, NZP}, {13'b0, mon_e.nzp});
                end
            end
        end
    end

    task automatic load(input logic [2:0] a, input logic [15:0] d);
        @(negedge Clk);
        Wr_En   = 1'b1;
        Wr_Addr = a;
        Wr_Data = d;
        @(negedge Clk);
        Wr_En   = 1'b0;
    endtask

    task automatic check_reg(input string name, input logic [2:0] a, input logic [15:0] exp);
        Dbg_Sel = a;
        #1;
        check(name, Dbg_Data, exp);
    endtask

    task automatic wait_idle(input string name, input int acc, input int lat);
        int n = 0;
        while (!Instr_Ready && n < 10) begin
            @(negedge Clk);
            n++;
        end
        check(name, 16'(cyc - acc), 16'(lat));
    endtask

    task automatic issue_legal(input logic [15:0] ins, input logic [1:0] aluk,
                               input logic sr2mux, input logic [15:0] sr1,
                               input logic [15:0] sr2, input logic [2:0] nzp);
        int acc;
        @(negedge Clk);
        Instr       = ins;
        Instr_Valid = 1'b1;
        @(posedge Clk);
        #1;
        acc = cyc - 1;
        sb.push_back('{instr: ins, is_illegal: 1'b0, nzp: nzp, acc: acc});
        Instr_Valid = 1'b0;
        @(negedge Clk);  // cycle 1: DECODE
        @(negedge Clk);  // cycle 2: EXEC
        check("exec_aluk", {14'b0, ALUK}, {14'b0, aluk});
        check("exec_sr2mux", {15'b0, SR2MUX}, {15'b0, sr2mux});
        check("exec_sr1", SR1_Data, sr1);
        check("exec_sr2", SR2_Data, sr2);
        check("exec_not_ready", {15'b0, Instr_Ready}, 16'h0000);
        wait_idle("ready_after_legal", acc, 4);
    endtask

    initial begin
        int acc;
        Reset_n     = 1'b0;
        Instr_Valid = 1'b0;
        Instr       = '0;
        Wr_En       = 1'b0;
        Wr_Addr     = '0;
        Wr_Data     = '0;
        Dbg_Sel     = '0;

        // Reset values
        #12;
        @(negedge Clk);
        Reset_n = 1'b1;
        #1;
        check("rst_ready", {15'b0, Instr_Ready}, 16'h0001);
        check("rst_nzp", {13'b0, NZP}, 16'h0002);
        check("rst_aluk", {14'b0, ALUK}, 16'h0003);
        check("rst_sr2mux", {15'b0, SR2MUX}, 16'h0000);
        check("rst_done_illegal", {14'b0, Done, Illegal}, 16'h0000);
        check("rst_ir", IR_Out, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            check_reg("rst_reg", 3'(i), 16'h0000);
        end

        // Register loads
        load(3'd1, 16'h0005);
        load(3'd2, 16'hFFFD);
        check_reg("load_r1", 3'd1, 16'h0005);
        check_reg("load_r2", 3'd2, 16'hFFFD);

        // ADD R3,R1,R2 : 5 + -3 = 2
        issue_legal(16'h1642, 2'b00, 1'b0, 16'h0005, 16'hFFFD, 3'b001);
        check_reg("add_reg_r3", 3'd3, 16'h0002);

        // ADD R4,R1,#-16 : 5 - 16 = -11
        issue_legal(16'h1870, 2'b00, 1'b1, 16'h0005, 16'h0000, 3'b100);
        check_reg("add_imm_r4", 3'd4, 16'hFFF5);

        // AND R5,R2,#0
        issue_legal(16'h5AA0, 2'b01, 1'b1, 16'hFFFD, 16'h0000, 3'b010);
        check_reg("and_imm_r5", 3'd5, 16'h0000);

        // NOT R6,R1 (IR[5:0] all ones, ignored)
        issue_legal(16'h9C7F, 2'b10, 1'b0, 16'h0005, 16'h0000, 3'b100);
        check_reg("not_r6", 3'd6, 16'hFFFA);

        // Illegal opcode 0000
        @(negedge Clk);
        Instr       = 16'h0000;
        Instr_Valid = 1'b1;
        @(posedge Clk);
        #1;
        acc = cyc - 1;
        sb.push_back('{instr: 16'h0000, is_illegal: 1'b1, nzp: 3'b000, acc: acc});
        Instr_Valid = 1'b0;
        @(negedge Clk);  // cycle 1
        check("illegal_aluk", {14'b0, ALUK}, 16'h0003);
        wait_idle("ready_after_illegal", acc, 2);
        check("illegal_nzp_kept", {13'b0, NZP}, 16'h0004);
        check_reg("illegal_r3_kept", 3'd3, 16'h0002);
        check_reg("illegal_r6_kept", 3'd6, 16'hFFFA);

        // Held Instr_Valid and Wr_En through a busy instruction. The load of
        // R1=7 at the accept edge must be seen by DECODE: R3 = 7 + -3 = 4.
        @(negedge Clk);
        Instr       = 16'h1642;
        Instr_Valid = 1'b1;
        Wr_En       = 1'b1;
        Wr_Addr     = 3'd1;
        Wr_Data     = 16'h0007;
        @(posedge Clk);
        #1;
        acc = cyc - 1;
        sb.push_back('{instr: 16'h1642, is_illegal: 1'b0, nzp: 3'b001, acc: acc});
        Instr   = 16'h0000;
        Wr_Addr = 3'd7;
        Wr_Data = 16'h1234;
        @(negedge Clk);
        @(negedge Clk);  // cycle 2
        check("busy_not_ready", {15'b0, Instr_Ready}, 16'h0000);
        check("decode_sees_new_write", SR1_Data, 16'h0007);
        @(negedge Clk);  // cycle 3
        check("busy_ir_held", IR_Out, 16'h1642);
        Instr_Valid = 1'b0;
        Wr_En       = 1'b0;
        wait_idle("ready_after_busy", acc, 4);
        check_reg("busy_r3", 3'd3, 16'h0004);
        check_reg("busy_r7_not_written", 3'd7, 16'h0000);
        check_reg("busy_r1", 3'd1, 16'h0007);

        // Reset asserted mid-EXEC
        Dbg_Sel = 3'd3;
        @(negedge Clk);
        Instr       = 16'h1642;
        Instr_Valid = 1'b1;
        @(posedge Clk);
        #1;
        Instr_Valid = 1'b0;
        @(posedge Clk);  // edge 1: cycle 2 is EXEC
        #2;
        Reset_n = 1'b0;
        #1;
        check("midrst_ready", {15'b0, Instr_Ready}, 16'h0001);
        check("midrst_nzp", {13'b0, NZP}, 16'h0002);
        check("midrst_aluk", {14'b0, ALUK}, 16'h0003);
        check("midrst_done", {15'b0, Done}, 16'h0000);
        check("midrst_r3", Dbg_Data, 16'h0000);
        check("midrst_ir", IR_Out, 16'h0000);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (5) @(negedge Clk);
        check_reg("postrst_r3", 3'd3, 16'h0000);
        check("postrst_nzp", {13'b0, NZP}, 16'h0002);

        check("scoreboard_drained", 16'(sb.size()), 16'h0000);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
